// File: rtl/dct_pkg.sv
// Shared constants and controller state encoding for the 8x8 row-DCT sequencer.
package dct_pkg;
    localparam int N      = 8;
    localparam int PIX_W  = 8;
    localparam int COEF_W = 24;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_e;
endpackage

// File: rtl/dct_transpose_buf.sv
// 8x8 coefficient store: written one row at a time, read one column at a time.
module dct_transpose_buf
    import dct_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [2:0]            wr_row,
    input  logic [N*COEF_W-1:0]   wr_data,
    input  logic [2:0]            rd_col,
    output logic [N*COEF_W-1:0]   rd_data
);
    logic [COEF_W-1:0] mem_r [N][N];

    // Row write; left unreset because a full block always overwrites it before any read
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < N; k++) begin
                mem_r[wr_row][k] <= wr_data[k*COEF_W +: COEF_W];
            end
        end
    end

    // Column read: lane k comes from row k
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < N; k++) begin
            rd_data[k*COEF_W +: COEF_W] = mem_r[k][rd_col];
        end
    end
endmodule

// File: rtl/dct_row_seq.sv
// Row sequencer around an external combinational 8-point DCT core: feeds pixel
// rows, captures results after CORE_LAT cycles, then drains transposed columns.
module dct_row_seq
    import dct_pkg::*;
#(
    parameter int CORE_LAT = 1
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*PIX_W-1:0]    in_pix,
    output logic [N*PIX_W-1:0]    core_y,
    input  logic [N*COEF_W-1:0]   core_Y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*COEF_W-1:0]   out_col,
    output logic [2:0]            out_col_idx,
    output logic                  out_last,
    output logic                  busy
);
    localparam logic [1:0] LAT_END = 2'(CORE_LAT - 1);

    state_e              state_r;
    logic [2:0]          row_cnt_r;
    logic [2:0]          col_cnt_r;
    logic [1:0]          lat_cnt_r;
    logic [N*PIX_W-1:0]  core_y_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic                out_last_r;
    logic                busy_r;
    logic                wr_en_s;

    assign wr_en_s = (state_r == WAIT) && (lat_cnt_r == LAT_END);

    dct_transpose_buf u_buf (
        .clk     (clk),
        .we      (wr_en_s),
        .wr_row  (row_cnt_r),
        .wr_data (core_Y),
        .rd_col  (col_cnt_r),
        .rd_data (out_col)
    );

    // Controller FSM; handshake outputs are registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= LOAD;
            row_cnt_r   <= 3'd0;
            col_cnt_r   <= 3'd0;
            lat_cnt_r   <= 2'd0;
            core_y_r    <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                LOAD: begin
                    if (in_valid && in_ready_r) begin
                        core_y_r   <= in_pix;
                        lat_cnt_r  <= 2'd0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= WAIT;
                    end
                end
                WAIT: begin
                    lat_cnt_r <= lat_cnt_r + 2'd1;
                    if (wr_en_s) begin
                        if (row_cnt_r == 3'd7) begin
                            row_cnt_r   <= 3'd0;
                            col_cnt_r   <= 3'd0;
                            out_valid_r <= 1'b1;
                            out_last_r  <= 1'b0;
                            state_r     <= DRAIN;
                        end else begin
                            row_cnt_r  <= row_cnt_r + 3'd1;
                            in_ready_r <= 1'b1;
                            state_r    <= LOAD;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid_r && out_ready) begin
                        col_cnt_r <= col_cnt_r + 3'd1;
                        if (col_cnt_r == 3'd7) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            in_ready_r  <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= LOAD;
                        end else begin
                            out_last_r <= (col_cnt_r == 3'd6);
                        end
                    end
                end
                default: begin
                    state_r     <= LOAD;
                    row_cnt_r   <= 3'd0;
                    col_cnt_r   <= 3'd0;
                    lat_cnt_r   <= 2'd0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign core_y      = core_y_r;
    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_last    = out_last_r;
    assign out_col_idx = col_cnt_r;
    assign busy        = busy_r;
endmodule

// File: doc/dct_row_seq.md
DCT_ROW_SEQ -- requirements
Module: dct_row_seq

Interface
REQ-001 Parameter CORE_LAT, default 1: cycles from a core_y update until core_Y is sampled; legal range 1-4.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  an input pixel row is offered.
REQ-005 in_ready  out  1  the controller accepts a row this cycle.
REQ-006 in_pix  in  64  eight unsigned 8-bit pixels; lane k occupies bits [8k+7:8k].
REQ-007 core_y  out  64  row presented to the combinational 8-point DCT core; lane k drives core input yk.
REQ-008 core_Y  in  192  eight 24-bit core results; lane k occupies bits [24k+23:24k] (bit 23 sign, 16 integer bits, 7 fraction bits).
REQ-009 out_valid  out  1  a transposed column is available.
REQ-010 out_ready  in  1  the consumer accepts the column.
REQ-011 out_col  out  192  eight 24-bit coefficients of one column; lane k is the result of row k.
REQ-012 out_col_idx  out  3  index (0-7) of the column on out_col.
REQ-013 out_last  out  1  high with column 7.
REQ-014 busy  out  1  high in any state other than LOAD, or in LOAD when row_cnt is not 0.

Function
REQ-015 The state machine SHALL have three states: LOAD, WAIT and DRAIN. Registers: row_cnt (3 bits), col_cnt (3 bits), lat_cnt (2 bits).
REQ-016 LOAD: in_ready=1. On in_valid&&in_ready, the controller SHALL register in_pix into core_y, clear lat_cnt and enter WAIT.
REQ-017 WAIT: in_ready=0. lat_cnt SHALL increment each cycle. When lat_cnt==CORE_LAT-1, the controller SHALL write core_Y into buffer row row_cnt on that edge.
REQ-018 On that same edge: if row_cnt==7, row_cnt SHALL go to 0 and the state to DRAIN with col_cnt=0; otherwise row_cnt SHALL increment and the state return to LOAD.
REQ-019 Row throughput SHALL be 1+CORE_LAT cycles per row with in_valid held high.
REQ-020 The first out_valid SHALL occur 8*(1+CORE_LAT) cycles after the first row handshake.
REQ-021 DRAIN: out_valid=1, in_ready=0, out_col lane k = buffer[k][col_cnt], out_col_idx=col_cnt, out_last=(col_cnt==7).
REQ-022 In DRAIN, on out_valid&&out_ready, col_cnt SHALL increment. On the handshake with col_cnt==7, the state SHALL return to LOAD.
REQ-023 While out_ready=0, out_col, out_col_idx and out_last SHALL stay stable. A column SHALL never be skipped or repeated.
REQ-024 Coefficients SHALL be stored and emitted bit-exact; there is no rounding, saturation or sign handling.
REQ-025 core_y SHALL hold its value outside LOAD handshakes, so the core input is stable through WAIT and DRAIN.
REQ-026 in_valid SHALL be ignored outside LOAD. in_pix is don't-care when in_valid=0.
REQ-027 out_ready SHALL be ignored outside DRAIN.

Reset
REQ-028 When rst_n=0, the block SHALL immediately enter LOAD with row_cnt=col_cnt=lat_cnt=0.
REQ-029 Reset values: core_y=0, out_valid=0, out_last=0, out_col_idx=0, busy=0, in_ready=1 (LOAD).
REQ-030 Buffer contents SHALL be left unreset. Buffer data SHALL be unobservable until 8 fresh rows have been written.
REQ-031 Reset in the middle of a block SHALL discard the partial block. The next accepted row SHALL be row 0.

Structure
REQ-032 Package dct_pkg SHALL hold: N=8, PIX_W=8, COEF_W=24, and the state enum {LOAD, WAIT, DRAIN}.
REQ-033 Sub-module dct_transpose_buf SHALL hold 8x8xCOEF_W flops, with a 192-bit row write port (we, row address) and a 192-bit column read port (column address, combinational).
REQ-034 The combinational DCT core SHALL stay outside this block and connect only through core_y and core_Y.

Verification
REQ-035 Reset check: rst_n low during traffic -> same cycle: out_valid=0, in_ready=1, core_y=0, busy=0.
REQ-036 Transpose check: stub core where core_Y lane k = zero-extended core_y lane k; in_pix[r][k]=8r+k; out_ready=1 -> 8 beats, beat c lane k = 8k+c, out_col_idx 0..7, out_last only on beat 7.
REQ-037 Backpressure check: out_ready=0 for 5 cycles at column 3 -> out_col=column 3 stable; total of 8 distinct beats delivered.
REQ-038 Latency check: CORE_LAT=3, stub core delays by 3 cycles, in_valid pattern 1,0,1,1 -> in_ready low 3 cycles after each accept; all captured values correct; first out_valid 32 cycles after the first accept with in_valid held high.
REQ-039 Mid-drain reset: rst_n pulsed low at column 4 -> out_valid=0 immediately; a fresh block afterwards drains correct columns 0-7.
REQ-040 Back-to-back blocks: in_valid held high through DRAIN -> no accept until the cycle after the out_last handshake; the second block transposes correctly.
